// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO on the core data bus.
// Define MMIO_UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          DIV_WIDTH   = 16,
   parameter int          DEFAULT_DIV = 868
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic [31:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_data_write,
   input  logic [2:0]  funct3,
   output logic        hit,
   output logic [31:0] read_data,
   output logic        tx
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam logic PAR_EN = 1'b1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   localparam logic PAR_EN = 1'b0;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t               state, state_n;
   logic [7:0]           fifo [FIFO_DEPTH];
   logic [PW-1:0]        rd_ptr, wr_ptr;
   logic [CW-1:0]        count;
   logic [DIV_WIDTH-1:0] baud_div, bit_cnt, reload;
   logic [7:0]           data;
   logic [2:0]           bit_idx;
   logic [31:0]          status;
   logic                 overflow, pop, push, bit_end, empty, full;
   logic                 wr_txdata, wr_status, wr_div, unused_bits;

   assign hit       = mem_address[31:4] == BASE_ADDR[31:4];
   assign wr_txdata = hit && mem_write && mem_address[3:2] == 2'd0;
   assign wr_status = hit && mem_write && mem_address[3:2] == 2'd1;
   assign wr_div    = hit && mem_write && mem_address[3:2] == 2'd2 && funct3 == 3'b010;
   assign empty     = count == '0;
   assign full      = count == CW'(FIFO_DEPTH);
   // a pop in the same cycle frees a slot, so a full FIFO still accepts the push
   assign push      = wr_txdata && (!full || pop);
   assign reload    = baud_div == '0 ? '0 : baud_div - 1'b1;
   assign bit_end   = bit_cnt == '0;
   assign status    = {19'd0, 5'(count), 3'd0, PAR_EN, overflow, empty, full, state != IDLE};
   assign read_data = !(hit && mem_read) ? '0 :
                      mem_address[3:2] == 2'd1 ? status :
                      mem_address[3:2] == 2'd2 ? 32'(baud_div) : '0;
   assign tx        = state == START ? 1'b0 :
                      state == DATA  ? data[bit_idx] :
                      (state == STOP || state == IDLE) ? 1'b1 : ^data;
   assign unused_bits = ^{mem_address[1:0], mem_data_write};

   always_comb begin
      state_n = state;
      pop     = 1'b0;
      case (state)
         IDLE:  if (!empty) begin
                   pop     = 1'b1;
                   state_n = START;
                end
         START: if (bit_end) state_n = DATA;
`ifdef MMIO_UART_TX_PARITY_EN
         DATA:   if (bit_end && bit_idx == 3'd7) state_n = PARITY;
         PARITY: if (bit_end) state_n = STOP;
`else
         DATA:  if (bit_end && bit_idx == 3'd7) state_n = STOP;
`endif
         STOP:  if (bit_end) begin
                   pop     = !empty;
                   state_n = empty ? IDLE : START;
                end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (push) fifo[wr_ptr] <= mem_data_write[7:0];
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         baud_div <= DIV_WIDTH'(DEFAULT_DIV);
         bit_cnt  <= '0;
         bit_idx  <= '0;
         data     <= '0;
      end else begin
         state    <= state_n;
         // reloading only at bit boundaries makes divisor writes land on the next bit
         bit_cnt  <= (state == IDLE || bit_end) ? reload : bit_cnt - 1'b1;
         if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
         if (pop) begin
            data   <= fifo[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         count    <= count + CW'(push) - CW'(pop);
         overflow <= (wr_txdata && !push) || (overflow && !(wr_status && mem_data_write[3]));
         if (wr_div) baud_div <= mem_data_write[DIV_WIDTH-1:0];
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register table, directed frame sequences and randomized frames
// checked against a per-bit frame model and a byte scoreboard.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef MMIO_UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int          NBITS   = 10 + PAR;
   localparam logic [31:0] PAR_BIT = 32'(PAR) << 4;
   localparam logic [31:0] ST_IDLE = 32'h4 | PAR_BIT;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  f3;
      logic        we;
      logic        re;
      logic [31:0] wdata;
      logic        exp_hit;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk_in = 1'b0, reset = 1'b1;
   logic [31:0] mem_address = '0, mem_data_write = '0, read_data;
   logic        mem_read = 1'b0, mem_write = 1'b0, hit, tx;
   logic [2:0]  funct3 = 3'b010;
   int          checks = 0, errors = 0;
   logic [7:0]  exp_q [$];
   vec_t        tbl [$];

   mmio_uart_tx dut (
      .clk_in(clk_in), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_data_write(mem_data_write), .funct3(funct3),
      .hit(hit), .read_data(read_data), .tx(tx)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      @(negedge clk_in);
      mem_address = a; mem_data_write = d; funct3 = f; mem_write = 1'b1;
      @(posedge clk_in);
      #1 mem_write = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      @(negedge clk_in);
      mem_address = a; funct3 = 3'b010; mem_read = 1'b1;
      #1 chk(name, read_data, exp);
      mem_read = 1'b0;
   endtask

   // Frame model: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic exp_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (PAR == 1 && j == 9) return ^b;
      return 1'b1;
   endfunction

   task automatic recv_frame(input int div, input int max_wait, input bit chk_busy);
      int w;
      int d;
      logic [7:0] b;
      w = 0;
      d = div < 1 ? 1 : div;
      @(negedge clk_in);
      while (tx !== 1'b0 && w < max_wait) begin
         @(negedge clk_in);
         w++;
      end
      if (tx !== 1'b0) begin
         chk("frame_start", {31'd0, tx}, 32'd0);
         return;
      end
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_frame actual=start expected=idle");
         return;
      end
      b = exp_q.pop_front();
      for (int s = 0; s < NBITS * d; s++) begin
         if (s > 0) @(negedge clk_in);
         chk($sformatf("frame_%h_s%0d", b, s), {31'd0, tx}, {31'd0, exp_bit(b, s / d)});
         if (chk_busy) chk($sformatf("busy_s%0d", s), {31'd0, read_data[0]}, 32'd1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      reset = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      reset = 1'b0;
   endtask

   initial begin
      tbl.push_back('{BASE + 32'h4,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, ST_IDLE});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h364});
      tbl.push_back('{BASE,          3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0});
      tbl.push_back('{BASE + 32'hC,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h20, 3'b010, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0});
      tbl.push_back('{BASE + 32'h14, 3'b010, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0});
      tbl.push_back('{BASE + 32'h8,  3'b001, 1'b1, 1'b0, 32'h10,        1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h364});
      tbl.push_back('{BASE + 32'h20, 3'b010, 1'b1, 1'b0, 32'hAA,        1'b0, 32'h0});
      tbl.push_back('{BASE + 32'hC,  3'b010, 1'b1, 1'b0, 32'hFF,        1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h4,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, ST_IDLE});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b1, 1'b0, 32'h0001_2345, 1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2345});
      tbl.push_back('{BASE + 32'h8,  3'b000, 1'b1, 1'b0, 32'h7,         1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2345});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b1, 1'b0, 32'h364,       1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0});
      tbl.push_back('{BASE + 32'h8,  3'b010, 1'b0, 1'b1, 32'h0,         1'b1, 32'h364});

      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      reset = 1'b0;
      chk("reset_tx", {31'd0, tx}, 32'd1);

      foreach (tbl[i]) begin
         @(negedge clk_in);
         mem_address = tbl[i].addr; funct3 = tbl[i].f3; mem_data_write = tbl[i].wdata;
         mem_write = tbl[i].we; mem_read = tbl[i].re;
         #1;
         chk($sformatf("tbl%0d_hit", i), {31'd0, hit}, {31'd0, tbl[i].exp_hit});
         chk($sformatf("tbl%0d_rd", i), read_data, tbl[i].exp_rd);
         @(posedge clk_in);
         #1 mem_write = 1'b0; mem_read = 1'b0;
      end

      // single 0x55 frame at divisor 4, busy observed every cycle
      bus_wr(BASE + 32'h8, 32'd4, 3'b010);
      exp_q.push_back(8'h55);
      bus_wr(BASE, 32'hFFFF_FF55, 3'b000);
      @(negedge clk_in);
      mem_address = BASE + 32'h4; mem_read = 1'b1;
      #1;
      chk("pre_start_tx", {31'd0, tx}, 32'd1);
      chk("pre_start_status", read_data, 32'h100 | PAR_BIT);
      recv_frame(4, 0, 1);
      @(negedge clk_in);
      chk("post55_tx", {31'd0, tx}, 32'd1);
      chk("post55_status", read_data, ST_IDLE);
      mem_read = 1'b0;

      // back-to-back frames must not leave an idle gap
      bus_wr(BASE + 32'h8, 32'd2, 3'b010);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      bus_wr(BASE, 32'h01, 3'b010);
      bus_wr(BASE, 32'h02, 3'b010);
      mem_address = BASE + 32'h4; mem_read = 1'b1;
      recv_frame(2, 0, 1);
      recv_frame(2, 0, 1);
      @(negedge clk_in);
      chk("b2b_end_tx", {31'd0, tx}, 32'd1);
      chk("b2b_end_status", read_data, ST_IDLE);
      mem_read = 1'b0;

      // overflow: one in flight, eight queued, tenth dropped
      bus_wr(BASE + 32'h8, 32'd1000, 3'b010);
      repeat (10) bus_wr(BASE, 32'hC3, 3'b010);
      check_reg("ovf_status", BASE + 32'h4, 32'h80B | PAR_BIT);
      bus_wr(BASE + 32'h4, 32'h0, 3'b010);
      check_reg("ovf_keep", BASE + 32'h4, 32'h80B | PAR_BIT);
      bus_wr(BASE + 32'h4, 32'h8, 3'b000);
      check_reg("ovf_clear", BASE + 32'h4, 32'h803 | PAR_BIT);
      do_reset();
      check_reg("after_reset_status", BASE + 32'h4, ST_IDLE);

      // asynchronous reset in the middle of DATA
      bus_wr(BASE + 32'h8, 32'd4, 3'b010);
      bus_wr(BASE, 32'h00, 3'b000);
      repeat (7) @(negedge clk_in);
      chk("mid_data_tx", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      #1 chk("async_reset_tx", {31'd0, tx}, 32'd1);
      @(posedge clk_in);
      @(negedge clk_in);
      reset = 1'b0;
      chk("post_reset_tx", {31'd0, tx}, 32'd1);
      check_reg("post_reset_status", BASE + 32'h4, ST_IDLE);
      check_reg("post_reset_div", BASE + 32'h8, 32'h364);

`ifdef MMIO_UART_TX_PARITY_EN
      bus_wr(BASE + 32'h8, 32'd4, 3'b010);
      exp_q.push_back(8'h07);
      bus_wr(BASE, 32'h07, 3'b000);
      recv_frame(4, 1, 0);
      @(negedge clk_in);
      chk("par07_end_tx", {31'd0, tx}, 32'd1);
`endif

      // randomized bursts against the scoreboard, divisor 0 included
      for (int r = 0; r < 6; r++) begin
         int dv;
         int n;
         dv = $urandom_range(0, 6);
         n  = $urandom_range(1, 8);
         bus_wr(BASE + 32'h8, dv, 3'b010);
         fork
            begin
               logic [7:0] b;
               for (int k = 0; k < n; k++) begin
                  b = 8'($urandom);
                  exp_q.push_back(b);
                  bus_wr(BASE, {24'($urandom), b}, 3'($urandom_range(0, 2)));
                  repeat ($urandom_range(0, 3)) @(posedge clk_in);
               end
            end
            begin
               for (int k = 0; k < n; k++) recv_frame(dv, 200, 0);
            end
         join
         @(negedge clk_in);
         chk($sformatf("rand%0d_tx", r), {31'd0, tx}, 32'd1);
         check_reg($sformatf("rand%0d_status", r), BASE + 32'h4, ST_IDLE);
         chk($sformatf("rand%0d_q", r), exp_q.size(), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
